coincidence_histogram_scanner: RTL

- sysClk-domain controller that drives the coincidence recorder's command/status interface from the master side.
- Each run starts an acquisition and waits for it to complete, reads back one channel's histogram, and locates the rising edge of the sampled /2 reference.
- It then programs the coincidence sample count as edge + offset and requests a transmitter heartbeat realign.
- This replaces the software polling loop that currently sequences the recorder through sysGPIO_OUT/sysCsr.

---
 rtl/coincidence_histogram_scanner_pkg.sv | 37 +++
 rtl/coincidence_histogram_scanner_csr_poll.sv | 54 +++++
 rtl/coincidence_histogram_scanner.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/coincidence_histogram_scanner_pkg.sv
// Shared command/status layout, error codes and sequencer states for the
// coincidence recorder master-side controller. The recorder uses the same
// bit positions, so change them here only.
package coincidence_pkg;

    // Command word (gpioOut) fields
    localparam int CMD_START_BIT   = 31;
    localparam int CMD_COINC_BIT   = 30;
    localparam int CMD_REALIGN_BIT = 29;
    localparam int CMD_MUXSEL_LSB  = 24;

    // Status word (csrIn) fields; the readback address sits directly above the sum
    localparam int STAT_BUSY_BIT   = 31;
    localparam int STAT_MUXSEL_LSB = 24;
    localparam int STAT_SUM_LSB    = 0;

    // Run result codes
    localparam logic [1:0] ERR_OK         = 2'd0;
    localparam logic [1:0] ERR_TIMEOUT    = 2'd1;
    localparam logic [1:0] ERR_NO_EDGE    = 2'd2;
    localparam logic [1:0] ERR_MULTI_EDGE = 2'd3;

    typedef enum logic [3:0] {
        S_IDLE,
        S_CMD_START,
        S_WAIT_HI,
        S_WAIT_LO,
        S_READ,
        S_POLL,
        S_EVAL,
        S_JUDGE,
        S_CMD_COINC,
        S_CMD_REALIGN,
        S_FINISH
    } state_t;

endpackage

// File: rtl/coincidence_histogram_scanner_csr_poll.sv
// Wait-state watchdog and readback qualifier for the recorder status word.
// A readback is trusted only after the expected address/channel has been
// seen on two consecutive cycles, which filters mid-update glitches.
module coincidence_csr_poll #(
    parameter int TIMEOUT_CYCLES = 2**20,
    parameter int MUXSEL_WIDTH   = 1,
    parameter int ADDR_WIDTH     = 7
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_load,
    input  logic                    i_waiting,
    input  logic                    i_polling,
    input  logic [ADDR_WIDTH-1:0]   i_want_addr,
    input  logic [MUXSEL_WIDTH-1:0] i_want_chan,
    input  logic [ADDR_WIDTH-1:0]   i_rb_addr,
    input  logic [MUXSEL_WIDTH-1:0] i_rb_chan,
    output logic                    o_expired,
    output logic                    o_accept
);

    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TO_W-1:0] TO_LOAD = TO_W'(TIMEOUT_CYCLES - 1);

    logic [TO_W-1:0] r_count;
    logic            r_matched;
    logic            w_match;

    assign w_match   = i_polling && (i_rb_addr == i_want_addr) && (i_rb_chan == i_want_chan);
    assign o_accept  = w_match && r_matched;
    // Counter reads zero in the last permitted cycle of the wait state
    assign o_expired = i_waiting && (r_count == '0);

    // Watchdog: reload on wait-state entry, count down while waiting
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= TO_LOAD;
        end else if (i_waiting && (r_count != '0)) begin
            r_count <= r_count - 1'b1;
        end
    end

    // Remember whether the previous cycle already matched the request
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_matched <= 1'b0;
        end else begin
            r_matched <= w_match;
        end
    end

endmodule

// File: rtl/coincidence_histogram_scanner.sv
// Master-side sequencer for the coincidence recorder: runs an acquisition,
// scans one channel's histogram for the rising edge of the /2 reference,
// then programs coincidence = edge + offset and requests a realign.
module coincidence_histogram_scanner
    import coincidence_pkg::*;
#(
    parameter int CHANNEL_COUNT               = 2,
    parameter int SAMPLE_CLKS_PER_COINCIDENCE = 80,
    parameter int CYCLES_PER_ACQUISITION      = 1023,
    parameter int TIMEOUT_CYCLES              = 2**20,
    localparam int MUXSEL_WIDTH = $clog2(CHANNEL_COUNT),
    localparam int ADDR_WIDTH   = $clog2(SAMPLE_CLKS_PER_COINCIDENCE),
    localparam int SUM_WIDTH    = $clog2(CYCLES_PER_ACQUISITION + 1)
) (
    input  logic                    sysClk,
    input  logic                    sysReset,
    input  logic                    start,
    input  logic [MUXSEL_WIDTH-1:0] channel,
    input  logic [ADDR_WIDTH-1:0]   offset,
    output logic                    csrStrobe,
    output logic [31:0]             gpioOut,
    input  logic [31:0]             csrIn,
    output logic                    busy,
    output logic                    done,
    output logic [1:0]              error,
    output logic [ADDR_WIDTH-1:0]   edgeAddress,
    output logic [ADDR_WIDTH:0]     edgeCount
);

    localparam logic [ADDR_WIDTH-1:0] LAST      = ADDR_WIDTH'(SAMPLE_CLKS_PER_COINCIDENCE - 1);
    localparam logic [ADDR_WIDTH:0]   N_EXT     = (ADDR_WIDTH+1)'(SAMPLE_CLKS_PER_COINCIDENCE);
    localparam logic [ADDR_WIDTH:0]   CNT_ONE   = (ADDR_WIDTH+1)'(1);
    localparam logic [SUM_WIDTH-1:0]  THRESHOLD = SUM_WIDTH'((CYCLES_PER_ACQUISITION + 1) / 2);

    state_t                  r_state, w_next;
    logic [MUXSEL_WIDTH-1:0] r_chan;
    logic [ADDR_WIDTH-1:0]   r_offset, r_index, r_edge_addr;
    logic [ADDR_WIDTH:0]     r_edge_cnt;
    logic [SUM_WIDTH-1:0]    r_sum;
    logic [1:0]              r_error;
    logic [31:0]             r_gpio, w_cmd;
    logic                    r_prime, r_prev, r_coinc_sent;
    logic                    w_strobe, w_load, w_timeout, w_expired, w_accept, w_high;
    logic                    w_rec_busy, w_waiting, w_unused_csr;
    logic [MUXSEL_WIDTH-1:0] w_rb_chan;
    logic [ADDR_WIDTH-1:0]   w_rb_addr;
    logic [SUM_WIDTH-1:0]    w_rb_sum;

    // Wrap edge + offset back into the histogram range
    function automatic logic [ADDR_WIDTH-1:0] mod_add(input logic [ADDR_WIDTH-1:0] a,
                                                      input logic [ADDR_WIDTH-1:0] b);
        logic [ADDR_WIDTH:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s >= N_EXT) s = s - N_EXT;
        return s[ADDR_WIDTH-1:0];
    endfunction

    function automatic logic [ADDR_WIDTH:0] sat_inc(input logic [ADDR_WIDTH:0] c);
        return (c >= N_EXT) ? c : c + 1'b1;
    endfunction

    assign w_rec_busy   = csrIn[STAT_BUSY_BIT];
    assign w_rb_chan    = csrIn[STAT_MUXSEL_LSB +: MUXSEL_WIDTH];
    assign w_rb_addr    = csrIn[STAT_SUM_LSB + SUM_WIDTH +: ADDR_WIDTH];
    assign w_rb_sum     = csrIn[STAT_SUM_LSB +: SUM_WIDTH];
    assign w_unused_csr = ^csrIn;  // remaining status bits are not decoded here
    assign w_high       = (r_sum >= THRESHOLD);
    assign w_waiting    = (r_state == S_WAIT_HI) || (r_state == S_WAIT_LO) || (r_state == S_POLL);

    coincidence_csr_poll #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .MUXSEL_WIDTH   (MUXSEL_WIDTH),
        .ADDR_WIDTH     (ADDR_WIDTH)
    ) u_poll (
        .i_clk       (sysClk),
        .i_rst       (sysReset),
        .i_load      (w_load),
        .i_waiting   (w_waiting),
        .i_polling   (r_state == S_POLL),
        .i_want_addr (r_index),
        .i_want_chan (r_chan),
        .i_rb_addr   (w_rb_addr),
        .i_rb_chan   (w_rb_chan),
        .o_expired   (w_expired),
        .o_accept    (w_accept)
    );

    // State register
    always_ff @(posedge sysClk or posedge sysReset) begin
        if (sysReset) r_state <= S_IDLE;
        else          r_state <= w_next;
    end

    // Next state, strobe and command word; progress wins over a same-cycle timeout
    always_comb begin
        w_next    = r_state;
        w_strobe  = 1'b0;
        w_cmd     = r_gpio;
        w_timeout = 1'b0;
        case (r_state)
            S_IDLE:      if (start) w_next = S_CMD_START;
            S_CMD_START: begin
                w_strobe                = 1'b1;
                w_cmd                   = '0;
                w_cmd[CMD_START_BIT]    = 1'b1;
                w_next                  = S_WAIT_HI;
            end
            S_WAIT_HI: begin
                if (w_rec_busy)     w_next = S_WAIT_LO;
                else if (w_expired) begin w_next = S_FINISH; w_timeout = 1'b1; end
            end
            S_WAIT_LO: begin
                if (!w_rec_busy)    w_next = S_READ;
                else if (w_expired) begin w_next = S_FINISH; w_timeout = 1'b1; end
            end
            S_READ: begin
                w_strobe                                   = 1'b1;
                w_cmd                                      = '0;
                w_cmd[ADDR_WIDTH-1:0]                      = r_index;
                w_cmd[CMD_MUXSEL_LSB +: MUXSEL_WIDTH]      = r_chan;
                w_next                                     = S_POLL;
            end
            S_POLL: begin
                if (w_accept)       w_next = S_EVAL;
                else if (w_expired) begin w_next = S_FINISH; w_timeout = 1'b1; end
            end
            S_EVAL:      w_next = (!r_prime && (r_index == LAST)) ? S_JUDGE : S_READ;
            S_JUDGE:     w_next = (r_edge_cnt == CNT_ONE) ? S_CMD_COINC : S_FINISH;
            S_CMD_COINC: begin
                // Two cycles here: strobe, then one quiet cycle before the realign strobe
                if (!r_coinc_sent) begin
                    w_strobe              = 1'b1;
                    w_cmd                 = '0;
                    w_cmd[CMD_COINC_BIT]  = 1'b1;
                    w_cmd[ADDR_WIDTH-1:0] = mod_add(r_edge_addr, r_offset);
                end else begin
                    w_next = S_CMD_REALIGN;
                end
            end
            S_CMD_REALIGN: begin
                w_strobe               = 1'b1;
                w_cmd                  = '0;
                w_cmd[CMD_REALIGN_BIT] = 1'b1;
                w_next                 = S_FINISH;
            end
            S_FINISH:    w_next = S_IDLE;
            default:     w_next = S_IDLE;
        endcase
        w_load = (w_next != r_state) &&
                 ((w_next == S_WAIT_HI) || (w_next == S_WAIT_LO) || (w_next == S_POLL));
    end

    // Run datapath: latched request, scan index, edge tracking and result
    always_ff @(posedge sysClk or posedge sysReset) begin
        if (sysReset) begin
            r_gpio       <= '0;
            r_chan       <= '0;
            r_offset     <= '0;
            r_index      <= '0;
            r_prime      <= 1'b0;
            r_prev       <= 1'b0;
            r_sum        <= '0;
            r_error      <= ERR_OK;
            r_edge_addr  <= '0;
            r_edge_cnt   <= '0;
            r_coinc_sent <= 1'b0;
        end else begin
            r_gpio <= w_cmd;
            if (w_timeout) r_error <= ERR_TIMEOUT;
            case (r_state)
                S_IDLE: if (start) begin
                    r_chan     <= channel;
                    r_offset   <= offset;
                    r_error    <= ERR_OK;
                    r_edge_cnt <= '0;
                end
                S_WAIT_LO: if (!w_rec_busy) begin
                    // Read the last bin first so bin 0 sees its wrap-around neighbour
                    r_index <= LAST;
                    r_prime <= 1'b1;
                end
                S_POLL: if (w_accept) r_sum <= w_rb_sum;
                S_EVAL: begin
                    r_prev <= w_high;
                    if (r_prime) begin
                        r_prime <= 1'b0;
                        r_index <= '0;
                    end else begin
                        if (w_high && !r_prev) begin
                            if (r_edge_cnt == '0) r_edge_addr <= r_index;
                            r_edge_cnt <= sat_inc(r_edge_cnt);
                        end
                        if (r_index != LAST) r_index <= r_index + 1'b1;
                    end
                end
                S_JUDGE: begin
                    if (r_edge_cnt == '0)          r_error <= ERR_NO_EDGE;
                    else if (r_edge_cnt != CNT_ONE) r_error <= ERR_MULTI_EDGE;
                end
                S_CMD_COINC: r_coinc_sent <= !r_coinc_sent;
                default: ;
            endcase
        end
    end

    assign csrStrobe   = w_strobe;
    assign gpioOut     = w_cmd;
    assign busy        = (r_state != S_IDLE) && (r_state != S_FINISH);
    assign done        = (r_state == S_FINISH);
    assign error       = r_error;
    assign edgeAddress = r_edge_addr;
    assign edgeCount   = r_edge_cnt;

endmodule
